// File: rtl/psum_out_sched_if.sv
// Psum read bus plus result-coordinate handshake of the 3x3 output sequencer.
// The sequencer is the master; the psum buffer / adder / result sink is the slave.
interface psum_out_sched_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              re;
  logic [ADDR_W-1:0] ra;
  logic              acc_clr;
  logic              acc_en;
  logic              o_valid;
  logic              o_ready;
  logic [7:0]        o_row;
  logic [7:0]        o_col;

  modport master (
    output re,
    output ra,
    output acc_clr,
    output acc_en,
    output o_valid,
    output o_row,
    output o_col,
    input  o_ready
  );

  modport slave (
    input  re,
    input  ra,
    input  acc_clr,
    input  acc_en,
    input  o_valid,
    input  o_row,
    input  o_col,
    output o_ready
  );
endinterface

// File: rtl/psum_out_sched.sv
// 3x3 partial-sum output sequencer: scans tile positions, issues nine tap reads per
// valid window, drives the accumulator controls and hands out result coordinates.
module psum_out_sched #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NTAP   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             top_level_state,
  input  logic                   start,
  input  logic [NTAP*ADDR_W-1:0] address_base,
  input  logic [7:0]             wid,
  input  logic [15:0]            tile_size,
  input  logic [7:0]             output_row_base,
  input  logic [7:0]             output_col_base,
  output logic                   busy,
  output logic                   done,
  psum_out_sched_if.master       bus
);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StRead,
    StDrain,
    StOut,
    StDone
  } state_e;

  state_e state_q, state_d;

  // num is one bit wider than tile_size so the end test cannot wrap.
  logic [16:0]       num_q, num_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [3:0]        tap_q, tap_d;
  logic [1:0]        tcol_q, tcol_d;
  logic [ADDR_W-1:0] roff_q, roff_d;
  logic              re_dly_q, re_dly_d;
  logic [3:0]        tap_dly_q, tap_dly_d;
  logic [7:0]        orow_q, orow_d;
  logic [7:0]        ocol_q, ocol_d;

  logic              run;
  logic              win_ok;
  logic              at_end;
  logic              col_wrap;
  logic [ADDR_W-1:0] base_sel;
  logic [ADDR_W-1:0] ra_sum;

  assign run      = (top_level_state == 3'd4);
  assign at_end   = (num_q > {1'b0, tile_size});
  assign col_wrap = (col_q == (wid - 8'd1));
  assign win_ok   = (wid >= 8'd3) &&
                    (({1'b0, col_q} + 9'd3) <= {1'b0, wid}) &&
                    (({1'b0, row_q} + 9'd3) <= {1'b0, wid});

  always_comb begin
    base_sel = address_base[32'(tap_q) * ADDR_W +: ADDR_W];
  end

  // Column offset comes from tcol, row offset (0, wid, 2*wid) is accumulated in roff.
  assign ra_sum = base_sel + ADDR_W'(num_q) + ADDR_W'(tcol_q) + roff_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      num_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      tap_q     <= '0;
      tcol_q    <= '0;
      roff_q    <= '0;
      re_dly_q  <= 1'b0;
      tap_dly_q <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tap_q     <= tap_d;
      tcol_q    <= tcol_d;
      roff_q    <= roff_d;
      re_dly_q  <= re_dly_d;
      tap_dly_q <= tap_dly_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && run) state_d = StScan;
      StScan: begin
        if (at_end) begin
          state_d = StDone;
        end else if (win_ok) begin
          state_d = StRead;
        end
      end
      StRead:  if (tap_q == 4'd8) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (bus.o_ready) state_d = StScan;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Leaving the psum-output global state aborts the tile without a done pulse.
    if ((state_q != StIdle) && !run) begin
      state_d = StIdle;
    end
  end

  // Position, tap and result-coordinate counters.
  always_comb begin
    num_d     = num_q;
    row_d     = row_q;
    col_d     = col_q;
    tap_d     = tap_q;
    tcol_d    = tcol_q;
    roff_d    = roff_q;
    re_dly_d  = (state_q == StRead) && (state_d != StIdle);
    tap_dly_d = tap_q;

    if ((state_q == StIdle) && (state_d == StScan)) begin
      num_d = '0;
      row_d = '0;
      col_d = '0;
    end

    if (((state_q == StScan) && (state_d == StScan)) ||
        ((state_q == StOut) && (state_d == StScan))) begin
      num_d = num_q + 17'd1;
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end

    if ((state_q == StScan) && (state_d == StRead)) begin
      tap_d  = '0;
      tcol_d = '0;
      roff_d = '0;
    end

    if ((state_q == StRead) && (state_d == StRead)) begin
      tap_d = tap_q + 4'd1;
      if (tcol_q == 2'd2) begin
        tcol_d = '0;
        roff_d = roff_q + ADDR_W'(wid);
      end else begin
        tcol_d = tcol_q + 2'd1;
      end
    end

    // Coordinates are captured on entry to OUT and held until the handshake.
    if (state_d == StOut) begin
      if (state_q == StOut) begin
        orow_d = orow_q;
        ocol_d = ocol_q;
      end else begin
        orow_d = output_row_base + row_q;
        ocol_d = output_col_base + col_q;
      end
    end else begin
      orow_d = '0;
      ocol_d = '0;
    end
  end

  // Outputs.
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    bus.re      = (state_q == StRead);
    bus.ra      = (state_q == StRead) ? ra_sum : '0;
    bus.acc_clr = re_dly_q && (tap_dly_q == 4'd0);
    bus.acc_en  = re_dly_q && (tap_dly_q != 4'd0);
    bus.o_valid = (state_q == StOut);
    bus.o_row   = orow_q;
    bus.o_col   = ocol_q;
  end

endmodule

// File: tb/tb_psum_out_sched.sv
// Scoreboard bench for psum_out_sched: a tile-level model fills expected read-address
// and result queues; a negedge monitor pops and compares as the DUT produces them.
module tb_psum_out_sched;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    tls;
  logic          start;
  logic [9*AW-1:0] abase;
  logic [7:0]    wid;
  logic [15:0]   tsz;
  logic [7:0]    rb;
  logic [7:0]    cb;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_out_sched_if #(.ADDR_W(AW)) bus ();

  psum_out_sched #(.ADDR_W(AW), .NTAP(9)) dut (
    .clk             (clk),
    .rst             (rst),
    .top_level_state (tls),
    .start           (start),
    .address_base    (abase),
    .wid             (wid),
    .tile_size       (tsz),
    .output_row_base (rb),
    .output_col_base (cb),
    .busy            (busy),
    .done            (done),
    .bus             (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  logic [15:0] exp_ra_q[$];
  int          exp_k_q[$];
  logic [15:0] exp_res_q[$];

  int done_cnt = 0, clr_cnt = 0, en_cnt = 0, res_cnt = 0;
  int b_done, b_clr, b_en, b_res;
  bit prev_re = 1'b0;
  bit prev_ok = 1'b0;
  int prev_k  = 0;

  // o_ready driver: fixed level or random per cycle.
  bit rdy_mode  = 1'b0;
  bit rdy_fixed = 1'b1;
  always @(posedge clk) begin
    #2;
    bus.o_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Monitor.
  always @(negedge clk) begin
    bit exp_clr, exp_en;
    logic [15:0] e;
    exp_clr = prev_re && prev_ok && (prev_k == 0);
    exp_en  = prev_re && prev_ok && (prev_k != 0);
    if (bus.acc_clr || exp_clr) check("acc_clr", 32'(bus.acc_clr), 32'(exp_clr));
    if (bus.acc_en || exp_en) check("acc_en", 32'(bus.acc_en), 32'(exp_en));
    if (bus.acc_clr) clr_cnt++;
    if (bus.acc_en) en_cnt++;
    prev_re = bus.re;
    prev_ok = (tls == 3'd4) && !rst;
    if (bus.re) begin
      if (exp_ra_q.size() == 0) begin
        check("unexpected_re", 32'd1, 32'd0);
      end else begin
        e      = exp_ra_q.pop_front();
        prev_k = exp_k_q.pop_front();
        check("ra", 32'(bus.ra), 32'(e));
      end
    end
    if (bus.o_valid && bus.o_ready) begin
      res_cnt++;
      if (exp_res_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_res_q.pop_front();
        check("row_col", {16'd0, bus.o_row, bus.o_col}, {16'd0, e});
      end
    end
    if (done) done_cnt++;
  end

  // Reference model: every position, division for row/col, explicit tap offsets.
  task automatic build_expect(output int nres);
    int w;
    int s;
    logic [15:0] ra_e;
    logic [7:0]  er, ec;
    w    = int'(wid);
    nres = 0;
    for (int n = 0; n <= int'(tsz); n++) begin
      int r, c;
      r = n / w;
      c = n % w;
      if (w >= 3 && c <= w - 3 && r <= w - 3) begin
        for (int k = 0; k < 9; k++) begin
          s    = int'(abase[k*16 +: 16]) + n + (k % 3) + (k / 3) * w;
          ra_e = s[15:0];
          exp_ra_q.push_back(ra_e);
          exp_k_q.push_back(k);
        end
        er = rb + 8'(r);
        ec = cb + 8'(c);
        exp_res_q.push_back({er, ec});
        nres++;
      end
    end
  endtask

  task automatic flush();
    exp_ra_q.delete();
    exp_k_q.delete();
    exp_res_q.delete();
  endtask

  task automatic start_tile();
    b_done = done_cnt;
    b_clr  = clr_cnt;
    b_en   = en_cnt;
    b_res  = res_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_tile(input string nm, input int nres);
    int cyc;
    cyc = 0;
    while (done_cnt == b_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_timeout"}, 32'(cyc < 20000), 32'd1);
    repeat (2) @(negedge clk);
    check({nm, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
    check({nm, "_res_cnt"}, 32'(res_cnt - b_res), 32'(nres));
    check({nm, "_clr_cnt"}, 32'(clr_cnt - b_clr), 32'(nres));
    check({nm, "_en_cnt"}, 32'(en_cnt - b_en), 32'(8 * nres));
    check({nm, "_ra_left"}, 32'(exp_ra_q.size()), 32'd0);
    check({nm, "_res_left"}, 32'(exp_res_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!bus.o_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_valid_seen"}, 32'(bus.o_valid), 32'd1);
  endtask

  task automatic cfg_base4();
    wid = 8'd4;
    tsz = 16'd15;
    rb  = 8'd10;
    cb  = 8'd20;
    for (int k = 0; k < 9; k++) abase[k*16 +: 16] = 16'(k * 16'h100);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_re"}, 32'(bus.re), 32'd0);
    check({nm, "_ra"}, 32'(bus.ra), 32'd0);
    check({nm, "_acc"}, {30'd0, bus.acc_clr, bus.acc_en}, 32'd0);
    check({nm, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({nm, "_rowcol"}, {16'd0, bus.o_row, bus.o_col}, 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nres;
    int nre;
    logic [7:0] hr, hc;
    rst = 1'b1; tls = 3'd4; start = 1'b0;
    abase = '0; wid = '0; tsz = '0; rb = '0; cb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Basic 4x4 tile, o_ready always high.
    cfg_base4();
    build_expect(nres);
    check("model_results_4x4", 32'(nres), 32'd4);
    start_tile();
    finish_tile("basic", nres);

    // Stall at the first result.
    rdy_fixed = 1'b0;
    build_expect(nres);
    start_tile();
    wait_valid("stall");
    hr = bus.o_row;
    hc = bus.o_col;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.o_valid), 32'd1);
      check("stall_hold", {16'd0, bus.o_row, bus.o_col}, {16'd0, hr, hc});
      check("stall_re", 32'(bus.re), 32'd0);
    end
    @(posedge clk); #1 rdy_fixed = 1'b1;
    @(negedge clk);
    check("stall_accept_valid", 32'(bus.o_valid), 32'd1);
    @(negedge clk);
    check("stall_released", 32'(bus.o_valid), 32'd0);
    finish_tile("stall", nres);

    // Tiny tile: only scanning, done exactly in cycle 6.
    wid = 8'd2;
    tsz = 16'd3;
    build_expect(nres);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cy = 1; cy <= 7; cy++) begin
      @(negedge clk);
      check("w2_busy", 32'(busy), 32'(cy <= 6));
      check("w2_done", 32'(done), 32'(cy == 6));
      check("w2_re_valid", {30'd0, bus.re, bus.o_valid}, 32'd0);
    end

    // Abort during tap 4 of the second window.
    cfg_base4();
    build_expect(nres);
    start_tile();
    nre = 0;
    for (int cyc = 0; cyc < 500 && nre < 13; cyc++) begin
      @(negedge clk);
      if (bus.re) nre++;
    end
    check("abort_reads_seen", 32'(nre), 32'd13);
    @(posedge clk); #1 tls = 3'd3;
    @(negedge clk);
    check("abort_tap4_re", 32'(bus.re), 32'd1);
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    flush();
    tls = 3'd4;
    build_expect(nres);
    start_tile();
    finish_tile("after_abort", nres);

    // Synchronous reset while presenting a result.
    rdy_fixed = 1'b0;
    build_expect(nres);
    start_tile();
    wait_valid("rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid_out");
    flush();
    rdy_fixed = 1'b1;
    build_expect(nres);
    start_tile();
    finish_tile("after_rst", nres);

    // Address wrap.
    for (int k = 0; k < 9; k++) abase[k*16 +: 16] = 16'($urandom);
    abase[15:0]  = 16'hFFFF;
    abase[31:16] = 16'hFFFF;
    wid = 8'd3;
    tsz = 16'd8;
    rb  = 8'd7;
    cb  = 8'd250;
    build_expect(nres);
    check("wrap_model_tap1", 32'(exp_ra_q[1]), 32'h0000);
    start_tile();
    finish_tile("wrap", nres);

    // Randomized tiles with random back-pressure.
    rdy_mode = 1'b1;
    for (int t = 0; t < 15; t++) begin
      wid = 8'($urandom_range(1, 6));
      tsz = 16'($urandom_range(0, int'(wid) * int'(wid)));
      rb  = 8'($urandom);
      cb  = 8'($urandom);
      for (int k = 0; k < 9; k++) abase[k*16 +: 16] = 16'($urandom);
      build_expect(nres);
      start_tile();
      finish_tile("rand", nres);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
